seg7_tick_counter: RTL

- Downstream display stage for the tile top.
- Divides the system clock into a slow tick and steps a 4-bit digit up or down on each tick, under switch-level controls.
- Drives the 7-segment outputs with the registered encoding of that digit.
- Switch inputs are asynchronous to clk; the block synchronises them itself.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_encode.sv | 11 +
 rtl/seg7_tick_counter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared widths, limits and segment table for the tick counter display
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEC_LIMIT = 4'd9;
    localparam logic [DIGIT_W-1:0] HEX_LIMIT = 4'd15;

    localparam logic [SEG_W-1:0] SEG_RESET = 7'h3F;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SEG_W-1:0]   seg_t;

    // Index 0 is the rightmost entry; bit0=a .. bit6=g, active high.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic digit_t digit_limit(input logic hex_mode);
        return hex_mode ? HEX_LIMIT : DEC_LIMIT;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational digit to 7-segment lookup
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg
);

    assign o_seg = SEG_TABLE[i_digit];

endmodule

// File: rtl/seg7_tick_counter.sv
// rtl/seg7_tick_counter.sv - prescaled up/down digit counter driving a registered 7-segment display
module seg7_tick_counter
    import seg7_pkg::*;
#(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter int          PRESC_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               run_sw,
    input  logic               up_sw,
    input  logic               hex_sw,
    input  logic               load_sw,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [SEG_W-1:0]   seg_out,
    output logic               dp_out,
    output logic [DIGIT_W-1:0] digit,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] TERM = PRESC_W'(MAX_COUNT - 24'd1);

    logic r_run_s1, r_run_s2;
    logic r_up_s1, r_up_s2;
    logic r_hex_s1, r_hex_s2;
    logic r_load_s1, r_load_s2, r_load_s3;

    logic [PRESC_W-1:0] r_presc;
    digit_t             r_digit;
    logic               r_dp;
    seg_t               r_seg;

    logic               w_active;
    logic               w_tick;
    logic               w_load;
    digit_t             w_limit;
    logic [PRESC_W-1:0] w_presc_nxt;
    digit_t             w_digit_nxt;
    logic               w_dp_nxt;
    seg_t               w_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_up_s1   <= 1'b0;
            r_up_s2   <= 1'b0;
            r_hex_s1  <= 1'b0;
            r_hex_s2  <= 1'b0;
            r_load_s1 <= 1'b0;
            r_load_s2 <= 1'b0;
            r_load_s3 <= 1'b0;
        end else begin
            r_run_s1  <= run_sw;
            r_run_s2  <= r_run_s1;
            r_up_s1   <= up_sw;
            r_up_s2   <= r_up_s1;
            r_hex_s1  <= hex_sw;
            r_hex_s2  <= r_hex_s1;
            r_load_s1 <= load_sw;
            r_load_s2 <= r_load_s1;
            r_load_s3 <= r_load_s2;
        end
    end

    // The load edge detector keeps running with ena low; only its effect is gated.
    assign w_active = ena & r_run_s2;
    assign w_tick   = w_active & (r_presc == TERM);
    assign w_load   = ena & r_load_s2 & ~r_load_s3;
    assign w_limit  = digit_limit(r_hex_s2);

    always_comb begin
        w_presc_nxt = r_presc;
        if (w_load) begin
            w_presc_nxt = '0;
        end else if (w_tick) begin
            w_presc_nxt = '0;
        end else if (w_active) begin
            w_presc_nxt = r_presc + 1'b1;
        end
    end

    // A digit above the decimal limit after a hex->dec switch is treated as past the top.
    always_comb begin
        w_digit_nxt = r_digit;
        w_dp_nxt    = r_dp;
        if (w_load) begin
            w_digit_nxt = (!r_hex_s2 && (load_val > DEC_LIMIT)) ? '0 : load_val;
            w_dp_nxt    = 1'b0;
        end else if (w_tick) begin
            if (r_up_s2) begin
                if (r_digit >= w_limit) begin
                    w_digit_nxt = '0;
                    w_dp_nxt    = 1'b1;
                end else begin
                    w_digit_nxt = r_digit + 1'b1;
                    w_dp_nxt    = 1'b0;
                end
            end else begin
                if (r_digit == '0) begin
                    w_digit_nxt = w_limit;
                    w_dp_nxt    = 1'b1;
                end else if (r_digit > w_limit) begin
                    w_digit_nxt = w_limit;
                    w_dp_nxt    = 1'b0;
                end else begin
                    w_digit_nxt = r_digit - 1'b1;
                    w_dp_nxt    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_digit <= '0;
            r_dp    <= 1'b0;
            r_seg   <= SEG_RESET;
        end else begin
            r_presc <= w_presc_nxt;
            r_digit <= w_digit_nxt;
            r_dp    <= w_dp_nxt;
            r_seg   <= w_seg;
        end
    end

    seg7_encode u_encode (
        .i_digit (r_digit),
        .o_seg   (w_seg)
    );

    assign seg_out = r_seg;
    assign dp_out  = r_dp;
    assign digit   = r_digit;
    assign tick    = w_tick;

endmodule
